// File: rtl/spram_pkg.sv
// Shared types and constants for the SPRAM256KA behavioural model.
// Optional feature macro: SPRAM_POWEROFF_LOSS_EN (see spram256ka_model.sv).
package spram_pkg;

    localparam int SPRAM_ADDR_WIDTH = 14;
    localparam int SPRAM_DATA_WIDTH = 16;
    localparam int SPRAM_NIBBLES    = SPRAM_DATA_WIDTH / 4;

    typedef logic [SPRAM_DATA_WIDTH-1:0] spram_word_t;
    typedef logic [SPRAM_NIBBLES-1:0]    spram_mask_t;

    // What the macro does on a given edge, after control-input priority.
    typedef enum logic [2:0] {
        MODE_OFF,    // poweroff=0: output forced to zero
        MODE_SLEEP,  // sleep=1: output forced to zero
        MODE_IDLE,   // standby=1 or chipselect=0: output held
        MODE_WRITE,  // active write
        MODE_READ    // active read
    } spram_mode_e;

    // Resolves the low-power and select inputs in their priority order.
    function automatic spram_mode_e decode_mode(
        input logic poweroff,
        input logic sleep,
        input logic standby,
        input logic chipselect,
        input logic wren
    );
        if (!poweroff)                 return MODE_OFF;
        else if (sleep)                return MODE_SLEEP;
        else if (standby || !chipselect) return MODE_IDLE;
        else if (wren)                 return MODE_WRITE;
        else                           return MODE_READ;
    endfunction

endpackage

// File: rtl/spram256ka_model_if.sv
// Access bus of the SPRAM256KA model: address/data, masks and power controls.
interface spram256ka_model_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   datain;
    logic [DATA_WIDTH/4-1:0] maskwren;
    logic                    wren;
    logic                    chipselect;
    logic                    standby;
    logic                    sleep;
    logic                    poweroff;
    logic [DATA_WIDTH-1:0]   dataout;

    modport master (
        output address, datain, maskwren, wren, chipselect, standby, sleep, poweroff,
        input  dataout
    );

    modport slave (
        input  address, datain, maskwren, wren, chipselect, standby, sleep, poweroff,
        output dataout
    );
endinterface

// File: rtl/spram_nibble_lane.sv
// One 4-bit-wide storage slice of the SPRAM; the top stacks DATA_WIDTH/4 of them.
module spram_nibble_lane #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            wdata,
    output logic [3:0]            rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // NOTE: the storage array has no reset; contents must survive wb_reset_n_i,
    // and the declaration initialiser gives the zero power-up image.
    logic [3:0] mem_q [DEPTH] = '{default: 4'h0};

    // Write port: one nibble per edge when this lane is enabled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples pre-edge values regardless of statement order.
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read port is combinational here; the top registers it into dataout.
    assign rdata = mem_q[addr];

endmodule

// File: rtl/spram256ka_model.sv
// SPRAM256KA 16K x 16 single-port RAM model with per-nibble write mask and
// low-power inputs. Optional feature macro: SPRAM_POWEROFF_LOSS_EN -- when
// defined, edges with poweroff=0 clear the array one word per edge.
module spram256ka_model
    import spram_pkg::*;
#(
    parameter int ADDR_WIDTH = SPRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SPRAM_DATA_WIDTH
) (
    input  logic                wb_clk_i,
    input  logic                wb_reset_n_i,
    spram256ka_model_if.slave   bus
);
    localparam int NIBBLES = DATA_WIDTH / 4;

    spram_mode_e             mode;
    logic [NIBBLES-1:0]      lane_we;
    logic [ADDR_WIDTH-1:0]   lane_addr;
    logic [DATA_WIDTH-1:0]   lane_wdata;
    logic [DATA_WIDTH-1:0]   lane_rdata;
    logic [DATA_WIDTH-1:0]   dataout_d;
    logic [DATA_WIDTH-1:0]   dataout_q;
`ifdef SPRAM_POWEROFF_LOSS_EN
    logic [ADDR_WIDTH-1:0]   clr_ptr_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q;
`endif

    assign mode = decode_mode(bus.poweroff, bus.sleep, bus.standby,
                              bus.chipselect, bus.wren);

    // Control decode: lane write enables, array address and next dataout.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        dataout_d  = dataout_q;
        lane_we    = '0;
        lane_addr  = bus.address;
        lane_wdata = bus.datain;
`ifdef SPRAM_POWEROFF_LOSS_EN
        clr_ptr_d  = clr_ptr_q;
`endif
        unique case (mode)
            MODE_OFF, MODE_SLEEP: dataout_d = '0;
            MODE_WRITE:           lane_we   = bus.maskwren;
            MODE_READ:            dataout_d = lane_rdata;
            default:              ;
        endcase
`ifdef SPRAM_POWEROFF_LOSS_EN
        // Loss of retention: sweep the array, one zeroed word per unpowered edge.
        if (mode == MODE_OFF) begin
            lane_we    = '1;
            lane_addr  = clr_ptr_q;
            lane_wdata = '0;
            clr_ptr_d  = clr_ptr_q + 1'b1;
        end
`endif
        // No array access of any kind while reset is held.
        if (!wb_reset_n_i) begin
            lane_we = '0;
        end
    end

    // Registered read data, cleared asynchronously by reset.
    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            dataout_q <= '0;
        end else begin
            dataout_q <= dataout_d;
        end
    end

`ifdef SPRAM_POWEROFF_LOSS_EN
    // Position of the retention-loss sweep.
    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            clr_ptr_q <= '0;
        end else begin
            clr_ptr_q <= clr_ptr_d;
        end
    end
`endif

    for (genvar k = 0; k < NIBBLES; k++) begin : g_lane
        spram_nibble_lane #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lane (
            .clk   (wb_clk_i),
            .we    (lane_we[k]),
            .addr  (lane_addr),
            .wdata (lane_wdata[4*k +: 4]),
            .rdata (lane_rdata[4*k +: 4])
        );
    end

    assign bus.dataout = dataout_q;

endmodule

// File: tb/tb_spram256ka_model.sv
// Self-checking bench for spram256ka_model: directed vector table, reset and
// power-off sequences, and randomized traffic against a word-array model.
module tb_spram256ka_model;
    import spram_pkg::*;

    localparam int AW    = SPRAM_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;

    logic clk;
    logic rst_n;

    spram256ka_model_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(SPRAM_DATA_WIDTH)) bus ();

    spram256ka_model #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (SPRAM_DATA_WIDTH)
    ) dut (
        .wb_clk_i     (clk),
        .wb_reset_n_i (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain word array plus the expected output register.
    spram_word_t m_mem [DEPTH];
    spram_word_t m_dout;

    typedef struct {
        string       name;
        logic        po, sl, sb, cs, we;
        logic [AW-1:0] addr;
        spram_word_t din;
        spram_mask_t mask;
        spram_word_t exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic po, logic sl, logic sb, logic cs,
                                logic we, logic [AW-1:0] addr, spram_word_t din,
                                spram_mask_t mask, spram_word_t exp);
        vec_t v;
        v.name = name; v.po = po; v.sl = sl; v.sb = sb; v.cs = cs; v.we = we;
        v.addr = addr; v.din = din; v.mask = mask; v.exp = exp;
        return v;
    endfunction

    task automatic check(string name, spram_word_t act, spram_word_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dataout=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_in(logic po, logic sl, logic sb, logic cs, logic we,
                          logic [AW-1:0] addr, spram_word_t din, spram_mask_t mask);
        bus.poweroff   = po;
        bus.sleep      = sl;
        bus.standby    = sb;
        bus.chipselect = cs;
        bus.wren       = we;
        bus.address    = addr;
        bus.datain     = din;
        bus.maskwren   = mask;
    endtask

    // Applies the behavioural rules to the model for the coming edge.
    task automatic model_edge();
        if (!rst_n) begin
            m_dout = '0;
        end else if (!bus.poweroff || bus.sleep) begin
            m_dout = '0;
        end else if (bus.standby || !bus.chipselect) begin
            // output holds, no access
        end else if (bus.wren) begin
            for (int k = 0; k < SPRAM_NIBBLES; k++)
                if (bus.maskwren[k]) m_mem[bus.address][4*k +: 4] = bus.datain[4*k +: 4];
        end else begin
            m_dout = m_mem[bus.address];
        end
    endtask

    // One clock: update model, take the edge, settle to sample point.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(logic po, logic sl, logic sb, logic cs, logic we,
                         logic [AW-1:0] addr, spram_word_t din, spram_mask_t mask);
        @(negedge clk);
        set_in(po, sl, sb, cs, we, addr, din, mask);
        step();
    endtask

    logic [AW-1:0] pool [6];

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_dout = '0;
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        check("reset_dataout", bus.dataout, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: po sl sb cs we addr din mask -> dataout after the edge.
        vecs.push_back(mk("wr5_full",      1,0,0,1,1, 14'd5,     16'h1234, 4'hF, 16'h0000));
        vecs.push_back(mk("rd5_full",      1,0,0,1,0, 14'd5,     16'h0000, 4'h0, 16'h1234));
        vecs.push_back(mk("wr5_mask0011",  1,0,0,1,1, 14'd5,     16'hABCD, 4'h3, 16'h1234));
        vecs.push_back(mk("rd5_mask0011",  1,0,0,1,0, 14'd5,     16'h0000, 4'h0, 16'h12CD));
        vecs.push_back(mk("wr5_restore",   1,0,0,1,1, 14'd5,     16'h1234, 4'hF, 16'h12CD));
        vecs.push_back(mk("wr5_mask1100",  1,0,0,1,1, 14'd5,     16'hABCD, 4'hC, 16'h12CD));
        vecs.push_back(mk("rd5_mask1100",  1,0,0,1,0, 14'd5,     16'h0000, 4'h0, 16'hAB34));
        vecs.push_back(mk("wr5_cs0",       1,0,0,0,1, 14'd5,     16'hFFFF, 4'hF, 16'hAB34));
        vecs.push_back(mk("rd5_after_cs0", 1,0,0,1,0, 14'd5,     16'h0000, 4'h0, 16'hAB34));
        vecs.push_back(mk("wr5_mask0",     1,0,0,1,1, 14'd5,     16'hFFFF, 4'h0, 16'hAB34));
        vecs.push_back(mk("rd5_after_m0",  1,0,0,1,0, 14'd5,     16'h0000, 4'h0, 16'hAB34));
        vecs.push_back(mk("wr7",           1,0,0,1,1, 14'd7,     16'h5555, 4'hF, 16'hAB34));
        vecs.push_back(mk("rd7_standby",   1,0,1,1,0, 14'd7,     16'h0000, 4'h0, 16'hAB34));
        vecs.push_back(mk("rd7",           1,0,0,1,0, 14'd7,     16'h0000, 4'h0, 16'h5555));
        vecs.push_back(mk("sleep_rd",      1,1,0,1,0, 14'd7,     16'h0000, 4'h0, 16'h0000));
        vecs.push_back(mk("sleep_wr5",     1,1,0,1,1, 14'd5,     16'h0000, 4'hF, 16'h0000));
        vecs.push_back(mk("rd5_post_sleep",1,0,0,1,0, 14'd5,     16'h0000, 4'h0, 16'hAB34));
        vecs.push_back(mk("wr_top",        1,0,0,1,1, 14'd16383, 16'hBEEF, 4'hF, 16'hAB34));
        vecs.push_back(mk("wr_zero",       1,0,0,1,1, 14'd0,     16'h0001, 4'hF, 16'hAB34));
        vecs.push_back(mk("rd_top",        1,0,0,1,0, 14'd16383, 16'h0000, 4'h0, 16'hBEEF));
        vecs.push_back(mk("rd_zero",       1,0,0,1,0, 14'd0,     16'h0000, 4'h0, 16'h0001));
        vecs.push_back(mk("rd_unwritten1", 1,0,0,1,0, 14'd1,     16'h0000, 4'h0, 16'h0000));
        vecs.push_back(mk("rd_unwr_16382", 1,0,0,1,0, 14'd16382, 16'h0000, 4'h0, 16'h0000));
        vecs.push_back(mk("rd_top_again",  1,0,0,1,0, 14'd16383, 16'h0000, 4'h0, 16'hBEEF));

        foreach (vecs[i]) begin
            do_op(vecs[i].po, vecs[i].sl, vecs[i].sb, vecs[i].cs, vecs[i].we,
                  vecs[i].addr, vecs[i].din, vecs[i].mask);
            check(vecs[i].name, bus.dataout, vecs[i].exp);
        end

        // Asynchronous reset between edges, with a write pending that must not land.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", bus.dataout, 16'h0000);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 14'd16383, 16'h0000, 4'hF);
        step();
        check("reset_held_dataout", bus.dataout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'd16383, 16'h0000, 4'h0);
        step();
        check("rd_top_after_reset", bus.dataout, 16'hBEEF);

        // Randomized traffic, compared to the model every cycle.
        pool[0] = 14'd0; pool[1] = 14'd1; pool[2] = 14'd5;
        pool[3] = 14'd7; pool[4] = 14'd16382; pool[5] = 14'd16383;
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 7) == 0) a = AW'($urandom);
            else a = pool[$urandom_range(0, 5)];
            do_op(1'b1,
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 1)),
                  a, 16'($urandom), 4'($urandom));
            check("random", bus.dataout, m_dout);
        end

        // Power-off sweep covering every word, then read back the top address.
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 14'd16383, 16'hBEEF, 4'hF);
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'd16383, 16'h0000, 4'h0);
        check("rd_top_pre_off", bus.dataout, 16'hBEEF);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'd16383, 16'h0000, 4'h0);
        step();
        check("poweroff_first_edge", bus.dataout, 16'h0000);
        for (int i = 1; i < DEPTH; i++) begin
            model_edge();
            @(posedge clk);
        end
        #1;
        check("poweroff_last_edge", bus.dataout, 16'h0000);
`ifdef SPRAM_POWEROFF_LOSS_EN
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
`endif
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'd16383, 16'h0000, 4'h0);
`ifdef SPRAM_POWEROFF_LOSS_EN
        check("rd_top_post_off", bus.dataout, 16'h0000);
`else
        check("rd_top_post_off", bus.dataout, 16'hBEEF);
`endif
        do_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14'd7, 16'h0000, 4'h0);
        check("rd7_post_off", bus.dataout, m_dout);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
